// File: rtl/sram_controller_pkg.sv
// Shared types for the external data-SRAM bridge.
// FSM encoding and data-segment base used by controller and freeze logic.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } sram_state_e;

  localparam int unsigned DATA_BASE_DEF = 1024;

endpackage

// File: rtl/sram_controller.sv
// 32-bit MEM-stage port to 16-bit async SRAM bridge, two half-word phases.
// Ports: clk/rst, wr_en/rd_en/address/write_data in, read_data/ready out, SRAM bus.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned DATA_BASE   = DATA_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  wire  [15:0]       sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  sram_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-2:0] word_w;
  logic              last;
  logic              phase;
  logic              dq_oe;
  logic [15:0]       dq_out;

  assign word_w = (ADDR_W-1)'((address - 32'(DATA_BASE)) >> 2);
  assign last   = (cnt_q == LAST);
  assign phase  = (state_q == S_LOW) || (state_q == S_HIGH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          state_d = S_LOW;
          cnt_d   = '0;
          op_wr_d = wr_en;
          word_d  = word_w;
          wdata_d = write_data;
          addr_d  = {word_w, 1'b0};
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          if (!op_wr_q) rdata_d[15:0] = sram_dq;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!op_wr_q) rdata_d[31:16] = sram_dq;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Last write cycle releases we_n so address/data are held across the
  // rising edge; a single-cycle phase has no spare cycle for that.
  always_comb begin
    ready     = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = (state_q == S_LOW) ? wdata_q[15:0] : wdata_q[31:16];
    unique case (state_q)
      S_IDLE: ready = !(rd_en || wr_en);
      S_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (phase) begin
      if (op_wr_q) begin
        dq_oe     = 1'b1;
        sram_we_n = !(!last || (WAIT_CYCLES == 1));
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign sram_dq   = dq_oe ? dq_out : 16'hzzzz;
  assign sram_addr = addr_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with behavioural async SRAM models.
// Covers default WAIT_CYCLES=5 build and a WAIT_CYCLES=1 build.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n;
  logic        probe;

  logic        rd1;
  logic        wr1;
  logic [31:0] addr1, wd1;
  logic [31:0] read_data1;
  logic        ready1;
  wire  [15:0] dq1;
  logic [17:0] sram_addr1;
  logic        we1_n, oe1_n;

  logic [15:0] mem0 [2**18];
  logic [15:0] mem1 [2**18];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr1),
    .rd_en      (rd1),
    .address    (addr1),
    .write_data (wd1),
    .read_data  (read_data1),
    .ready      (ready1),
    .sram_dq    (dq1),
    .sram_addr  (sram_addr1),
    .sram_we_n  (we1_n),
    .sram_oe_n  (oe1_n)
  );

  // SRAM models: latch on we_n rise, drive bus while oe_n is low.
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem0[sram_addr] : 16'hzzzz;
  assign dq1     = (!oe1_n && we1_n) ? mem1[sram_addr1] : 16'hzzzz;
  // Probe driver: a released bus reads as the probe value, a driven one not.
  assign sram_dq = probe ? 16'h0000 : 16'hzzzz;

  always @(posedge sram_we_n) mem0[sram_addr] <= sram_dq;
  always @(posedge we1_n) mem1[sram_addr1] <= dq1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Issues one request and returns at the negedge where ready is back high.
  task automatic access(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input int chg_at, input logic [31:0] chg_a,
                        output int low, output logic first_rdy,
                        output logic [17:0] lo_a, output logic [17:0] hi_a);
    @(posedge clk); #1;
    wr_en = w;
    rd_en = r;
    address = a;
    write_data = d;
    low = 0;
    first_rdy = 1'b0;
    lo_a = '0;
    hi_a = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) first_rdy = ready;
      if (ready) break;
      low++;
      if (i == 1) lo_a = sram_addr;
      hi_a = sram_addr;
      if (i == chg_at) address = chg_a;
    end
  endtask

  task automatic probe_z(input string tag);
    probe = 1'b1;
    #1;
    chk(tag, {16'h0, sram_dq}, 32'h0);
    probe = 1'b0;
  endtask

  int          low;
  logic        frdy;
  logic [17:0] la, ha;

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = '0;
    write_data = '0;
    probe = 1'b0;
    rd1 = 1'b0;
    wr1 = 1'b0;
    addr1 = '0;
    wd1 = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    probe_z("rst_dq_z");

    access(1, 0, 32'd1024, 32'hDEADBEEF, -1, 0, low, frdy, la, ha);
    chk("wr_low_cycles", low, 32'd11);
    idle();
    chk("wr_mem0", {16'h0, mem0[0]}, 32'h0000BEEF);
    chk("wr_mem1", {16'h0, mem0[1]}, 32'h0000DEAD);
    chk("wr_keeps_rdata", read_data, 32'h0);

    access(0, 1, 32'd1024, 32'h0, -1, 0, low, frdy, la, ha);
    chk("rd_low_cycles", low, 32'd11);
    chk("rd_data", read_data, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    probe_z("idle_dq_z");

    access(1, 0, 32'd1028, 32'h12345678, -1, 0, low, frdy, la, ha);
    chk("b2b_wr_low", low, 32'd11);
    access(0, 1, 32'd1028, 32'h0, -1, 0, low, frdy, la, ha);
    chk("b2b_gap", {31'h0, frdy}, 32'h0);
    chk("b2b_rd_low", low, 32'd11);
    chk("b2b_rd_data", read_data, 32'h12345678);
    chk("b2b_mem2", {16'h0, mem0[2]}, 32'h00005678);
    chk("b2b_mem3", {16'h0, mem0[3]}, 32'h00001234);
    idle();

    access(1, 1, 32'd1032, 32'h55AA33CC, 3, 32'd1100, low, frdy, la, ha);
    idle();
    chk("prio_mem4", {16'h0, mem0[4]}, 32'h000033CC);
    chk("prio_mem5", {16'h0, mem0[5]}, 32'h000055AA);
    chk("latch_addr_lo", {14'h0, la}, 32'd4);
    chk("latch_addr_hi", {14'h0, ha}, 32'd5);
    chk("prio_rdata", read_data, 32'h12345678);

    @(posedge clk); #1;
    wr_en = 1'b1;
    address = 32'd1036;
    write_data = 32'hA1B2C3D4;
    repeat (9) @(negedge clk);
    chk("mid_busy", {31'h0, ready}, 32'h0);
    rst = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", {31'h0, ready}, 32'h1);
    chk("mid_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("mid_oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("mid_rdata", read_data, 32'h0);
    chk("mid_addr", {14'h0, sram_addr}, 32'h0);
    probe_z("mid_dq_z");

    mem1[8] = 16'hF00D;
    mem1[9] = 16'hCAFE;
    @(posedge clk); #1;
    rd1 = 1'b1;
    addr1 = 32'd1040;
    low = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready1) break;
      low++;
    end
    chk("w1_low_cycles", low, 32'd3);
    chk("w1_rd_data", read_data1, 32'hCAFEF00D);
    @(posedge clk); #1;
    rd1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle bridge between the MEM stage's 32-bit data-memory port and an external 16-bit asynchronous SRAM.
- Each 32-bit word is transferred as two 16-bit half-word accesses, low half first.
- Deasserts ready while an access is in flight; the top level ORs ~ready into the pipeline freeze so that IF..MEM registers hold.
- Sits directly downstream of the MEM stage and replaces its internal data-memory array.

Parameters:
- ADDR_W, 18: external SRAM address width, in half-words.
- WAIT_CYCLES, 5: clock cycles spent on each half-word access phase; legal values are 1 or more.
- DATA_BASE, 1024: byte offset subtracted from the CPU address before mapping.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- wr_en  in  1: write request from the MEM stage; held until ready=1.
- rd_en  in  1: read request from the MEM stage; held until ready=1.
- address  in  32: byte address (ALU result).
- write_data  in  32: store data (Val_Rm).
- read_data  out  32: load result to the MEM stage register.
- ready  out  1: 1 when no access is pending or completing; 0 means freeze the pipeline.
- sram_dq  inout  16: SRAM data bus.
- sram_addr  out  ADDR_W: SRAM half-word address.
- sram_we_n  out  1: SRAM write enable, active-low.
- sram_oe_n  out  1: SRAM output enable, active-low.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_dq=Z. Reset applied mid-access aborts the access immediately; no partial write is completed after reset.
- Address map: word = (address - DATA_BASE) >> 2, truncated to ADDR_W-1 bits. Low half is at {word,0}; high half is at {word,1}. Out-of-range addresses wrap silently.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If rd_en|wr_en: latch op, address and write_data; clear the counter; go to LOW.
  - wr_en has priority if both requests are asserted.
- LOW:
  - Drive the low-half address; the counter increments every cycle.
  - When counter==WAIT_CYCLES-1: go to HIGH and clear the counter.
- HIGH: same as LOW, using the high-half address. When counter==WAIT_CYCLES-1, go to DONE.
- DONE: one cycle, then return unconditionally to IDLE.
- ready:
  - Combinational.
  - In IDLE: ready = ~(rd_en|wr_en).
  - In LOW and HIGH: ready = 0.
  - In DONE: ready = 1.
- Latency: ready is low for exactly 1+2*WAIT_CYCLES cycles, then high for one cycle in DONE. With the default WAIT_CYCLES=5 that is 11 low cycles, with ready high on the 12th. The pipeline advances at the DONE edge, so a back-to-back request is seen in IDLE on the next cycle.
- Write:
  - During LOW and HIGH, sram_dq carries latched write_data[15:0] or [31:16] respectively.
  - sram_we_n=0 for every phase cycle except the last one, which gives address/data hold. With WAIT_CYCLES=1, sram_we_n stays 0 for the single phase cycle.
  - sram_oe_n stays 1.
- Read:
  - sram_dq is Z and sram_oe_n=0 during LOW and HIGH.
  - sram_dq is sampled on the final cycle of each phase into the matching half of read_data.
  - read_data is valid in DONE and holds until the next read captures new data. Writes leave read_data unchanged.
- Request inputs are ignored outside IDLE; the latched copies are used throughout the access.
- Outside LOW and HIGH: sram_dq=Z and sram_we_n=sram_oe_n=1. sram_addr keeps its last value.

Decomposition:
- Shared package holds the state encoding (IDLE/LOW/HIGH/DONE, 2 bits) and the DATA_BASE default, shared with the forwarding and hazard logic that uses the freeze.
- No RTL sub-module: FSM, counter and datapath fit in one module.
- The bench supplies a behavioural sram_model (2^ADDR_W x 16 array, write on we_n rising edge, drives dq when oe_n=0).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no requests. Required: ready=1, read_data=0, sram_dq=Z, sram_we_n=1, sram_oe_n=1.
- Write then read back:
  - wr_en, address=1024, write_data=0xDEADBEEF. Required: ready low for 11 cycles; SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - Then rd_en on the same address. Required: read_data=0xDEADBEEF in DONE.
- Back-to-back:
  - Write 0x12345678 to address 1028, then read address 1028 in the very next IDLE cycle. Required: SRAM[2]=0x5678, SRAM[3]=0x1234; read_data=0x12345678; exactly one ready=1 cycle between the two accesses.
- Priority and latch:
  - rd_en=wr_en=1 at address 1032. Required: a write is performed.
  - Then change address mid-access. Required: the sram_addr sequence is still {4,5}.
- Reset mid-access:
  - Assert rst in cycle 3 of the HIGH phase of a write. Required: next cycle is IDLE, sram_we_n=1, sram_dq=Z, read_data=0.
- WAIT_CYCLES=1 build: each access has ready low for 3 cycles; a read of preloaded 0xCAFEF00D returns correctly.
